uart_cmd_decoder: RTL and testbench

- Sits between the UART receiver and the flow-LED stage.
- Parses 3-byte command frames from the RX byte stream and drives a registered LED-enable level that feeds the flow-LED `en` input.
- Returns a one-byte ACK/NAK to the UART transmitter over a valid/ready handshake.
- Keeps a saturating protocol-error counter for debug.

---
 rtl/uart_cmd_decoder.sv | 172 +++++++++++++++++
 tb/tb_uart_cmd_decoder.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_cmd_decoder.sv
// -----------------------------------------------------------------------------
// uart_cmd_decoder
//
// Parses 3-byte command frames (HDR_BYTE, CMD, ~CMD) from the UART receive
// byte stream. It drives a registered LED-enable level for the flow-LED
// stage. It answers each complete frame with one ACK/NAK byte over a
// valid/ready handshake. It also keeps a saturating protocol-error counter
// for debug.
//
// Ports:
//   sys_clk   in   1  system clock, rising edge
//   rst       in   1  asynchronous, active-high reset
//   rx_data   in   8  received byte, qualified by rx_valid
//   rx_valid  in   1  single-cycle strobe, one byte per pulse
//   tx_data   out  8  response byte (ACK_BYTE / NAK_BYTE)
//   tx_valid  out  1  response available, held until accepted
//   tx_ready  in   1  transmitter accepts when tx_valid & tx_ready
//   led_en    out  1  enable level to the flow-LED stage
//   err_cnt   out  8  saturating protocol-error count
//
// All outputs come straight from flops. There is no combinational path from
// inputs to outputs.
// -----------------------------------------------------------------------------
module uart_cmd_decoder #(
    parameter logic [19:0] TIMEOUT_CYC = 20'd500_000,
    parameter logic [7:0]  HDR_BYTE    = 8'hAA,
    parameter logic [7:0]  ACK_BYTE    = 8'h06,
    parameter logic [7:0]  NAK_BYTE    = 8'h15
) (
    input  logic       sys_clk,
    input  logic       rst,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    output logic [7:0] tx_data,
    output logic       tx_valid,
    input  logic       tx_ready,
    output logic       led_en,
    output logic [7:0] err_cnt
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_GOT_HDR,
        ST_GOT_CMD,
        ST_RESP
    } state_t;

    localparam logic [7:0] CMD_STOP   = 8'h00;
    localparam logic [7:0] CMD_START  = 8'h01;
    localparam logic [7:0] CMD_TOGGLE = 8'h02;

    state_t      state_q;
    logic [7:0]  cmd_q;
    logic [19:0] tmo_q;
    logic        led_en_q;
    logic        tx_valid_q;
    logic [7:0]  tx_data_q;
    logic [7:0]  err_cnt_q;

    logic [7:0]  err_cnt_d;
    logic        tmo_last;
    logic        cmd_known;
    logic        chk_ok;

    // Error sources are mutually exclusive by state. Every error event
    // therefore loads this single saturating increment, and the count never
    // wraps.
    assign err_cnt_d = (err_cnt_q == 8'hFF) ? 8'hFF : err_cnt_q + 8'd1;

    // Terminal count of the inter-byte idle timer. A byte arriving in the same
    // cycle takes priority over the timeout.
    assign tmo_last  = (tmo_q == TIMEOUT_CYC - 20'd1);

    assign cmd_known = (cmd_q == CMD_STOP) || (cmd_q == CMD_START) ||
                       (cmd_q == CMD_TOGGLE);
    assign chk_ok    = (rx_data == ~cmd_q);

    // NOTE: the whole FSM and its registered outputs live in one clocked
    // block. Every assignment in it is non-blocking, so all updates take
    // effect together at the edge, and a read in the same block always sees
    // the value from before the edge.
    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            // NOTE: every register here, including the cmd latch, has a
            // defined reset value. A reset in the middle of a frame or a
            // response therefore leaves nothing stale behind.
            state_q    <= ST_IDLE;
            cmd_q      <= 8'h00;
            tmo_q      <= 20'd0;
            led_en_q   <= 1'b0;
            tx_valid_q <= 1'b0;
            tx_data_q  <= 8'h00;
            err_cnt_q  <= 8'h00;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    tmo_q <= 20'd0;
                    // Bytes other than the header resync silently.
                    if (rx_valid && (rx_data == HDR_BYTE)) begin
                        state_q <= ST_GOT_HDR;
                    end
                end

                ST_GOT_HDR: begin
                    if (rx_valid) begin
                        // Any value is taken as the command, including HDR_BYTE.
                        cmd_q   <= rx_data;
                        tmo_q   <= 20'd0;
                        state_q <= ST_GOT_CMD;
                    end else if (tmo_last) begin
                        tmo_q     <= 20'd0;
                        err_cnt_q <= err_cnt_d;
                        state_q   <= ST_IDLE;
                    end else begin
                        tmo_q <= tmo_q + 20'd1;
                    end
                end

                ST_GOT_CMD: begin
                    if (rx_valid) begin
                        tmo_q      <= 20'd0;
                        tx_valid_q <= 1'b1;
                        state_q    <= ST_RESP;
                        if (chk_ok && cmd_known) begin
                            tx_data_q <= ACK_BYTE;
                            // The cmd_known guard makes the default arm
                            // unreachable. It is kept so the case is full.
                            case (cmd_q)
                                CMD_STOP:   led_en_q <= 1'b0;
                                CMD_START:  led_en_q <= 1'b1;
                                CMD_TOGGLE: led_en_q <= ~led_en_q;
                                default:    led_en_q <= led_en_q;
                            endcase
                        end else begin
                            tx_data_q <= NAK_BYTE;
                            err_cnt_q <= err_cnt_d;
                        end
                    end else if (tmo_last) begin
                        tmo_q     <= 20'd0;
                        err_cnt_q <= err_cnt_d;
                        state_q   <= ST_IDLE;
                    end else begin
                        tmo_q <= tmo_q + 20'd1;
                    end
                end

                ST_RESP: begin
                    tmo_q <= 20'd0;
                    // A byte arriving while the response is pending is dropped
                    // and counted. This also holds in the handshake cycle.
                    if (rx_valid) begin
                        err_cnt_q <= err_cnt_d;
                    end
                    if (tx_valid_q && tx_ready) begin
                        tx_valid_q <= 1'b0;
                        state_q    <= ST_IDLE;
                    end
                end

                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign tx_data  = tx_data_q;
    assign tx_valid = tx_valid_q;
    assign led_en   = led_en_q;
    assign err_cnt  = err_cnt_q;

endmodule

// File: tb/tb_uart_cmd_decoder.sv
// -----------------------------------------------------------------------------
// tb_uart_cmd_decoder
//
// Directed testbench for uart_cmd_decoder, with TIMEOUT_CYC = 16.
// Inputs are driven 1 time unit after each rising edge. Outputs are sampled at
// the same point, so each sample shows the result of the edge just taken.
// -----------------------------------------------------------------------------
module tb_uart_cmd_decoder;

    logic       sys_clk;
    logic       rst;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       led_en;
    logic [7:0] err_cnt;

    int n_checks;
    int n_fail;

    uart_cmd_decoder #(
        .TIMEOUT_CYC (20'd16),
        .HDR_BYTE    (8'hAA),
        .ACK_BYTE    (8'h06),
        .NAK_BYTE    (8'h15)
    ) dut (
        .sys_clk  (sys_clk),
        .rst      (rst),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .led_en   (led_en),
        .err_cnt  (err_cnt)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock and settle just after the edge.
    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        tick();
        rx_valid = 1'b0;
    endtask

    // One byte every 10 cycles. Returns right after the edge that takes the
    // last byte.
    task automatic send_frame(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
        send_byte(b0);
        idle(9);
        send_byte(b1);
        idle(9);
        send_byte(b2);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst      = 1'b1;
        rx_data  = 8'h00;
        rx_valid = 1'b0;
        tx_ready = 1'b1;

        // ---------------- reset state ----------------
        idle(2);
        check("rst_led",      led_en,   1'b0);
        check("rst_tx_valid", tx_valid, 1'b0);
        check("rst_tx_data",  tx_data,  8'h00);
        check("rst_err",      err_cnt,  8'h00);
        rst = 1'b0;
        tick();

        // ---------------- start: AA,01,FE ----------------
        send_byte(8'hAA);
        idle(9);
        send_byte(8'h01);
        idle(9);
        check("start_led_before", led_en, 1'b0);
        send_byte(8'hFE);
        check("start_led",      led_en,   1'b1);
        check("start_tx_valid", tx_valid, 1'b1);
        check("start_tx_data",  tx_data,  8'h06);
        tick();
        check("start_tx_pulse", tx_valid, 1'b0);
        check("start_err",      err_cnt,  8'h00);

        // ---------------- toggle then stop ----------------
        send_frame(8'hAA, 8'h02, 8'hFD);
        check("toggle_led",      led_en,   1'b0);
        check("toggle_tx_valid", tx_valid, 1'b1);
        check("toggle_tx_data",  tx_data,  8'h06);
        tick();
        check("toggle_tx_done",  tx_valid, 1'b0);
        send_frame(8'hAA, 8'h00, 8'hFF);
        check("stop_led",      led_en,   1'b0);
        check("stop_tx_valid", tx_valid, 1'b1);
        check("stop_tx_data",  tx_data,  8'h06);
        tick();
        check("stop_err", err_cnt, 8'h00);

        // ---------------- bad check, unknown cmd ----------------
        send_frame(8'hAA, 8'h01, 8'h00);
        check("badchk_tx_valid", tx_valid, 1'b1);
        check("badchk_tx_data",  tx_data,  8'h15);
        check("badchk_led",      led_en,   1'b0);
        check("badchk_err",      err_cnt,  8'h01);
        tick();
        send_frame(8'hAA, 8'h07, 8'hF8);
        check("unk_tx_valid", tx_valid, 1'b1);
        check("unk_tx_data",  tx_data,  8'h15);
        check("unk_led",      led_en,   1'b0);
        check("unk_err",      err_cnt,  8'h02);
        tick();

        // ---------------- timeout (fresh reset) ----------------
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("tmo_rst_err", err_cnt, 8'h00);
        send_byte(8'hAA);
        for (int i = 1; i <= 20; i++) begin
            tick();
            check("tmo_no_tx", tx_valid, 1'b0);
            if (i == 15) check("tmo_err_before", err_cnt, 8'h00);
            if (i == 16) check("tmo_err_at16",   err_cnt, 8'h01);
        end
        check("tmo_err_after", err_cnt, 8'h01);
        check("tmo_led",       led_en,  1'b0);

        // Bytes landing exactly on the terminal count win over the timeout.
        send_byte(8'hAA);
        idle(15);
        send_byte(8'h01);
        idle(15);
        send_byte(8'hFE);
        check("edge_tx_valid", tx_valid, 1'b1);
        check("edge_tx_data",  tx_data,  8'h06);
        check("edge_led",      led_en,   1'b1);
        check("edge_err",      err_cnt,  8'h01);
        tick();

        // ---------------- backpressure, repeated start ----------------
        tx_ready = 1'b0;
        send_frame(8'hAA, 8'h01, 8'hFE);
        check("bp_led", led_en, 1'b1);
        for (int i = 0; i < 30; i++) begin
            if (i == 10) send_byte(8'h55);
            else         tick();
            check("bp_hold_valid", tx_valid, 1'b1);
            check("bp_hold_data",  tx_data,  8'h06);
        end
        check("bp_drop_err", err_cnt, 8'h02);
        // A header in the handshake cycle is still dropped and counted.
        tx_ready = 1'b1;
        send_byte(8'hAA);
        check("bp_done_valid", tx_valid, 1'b0);
        check("bp_hs_err",     err_cnt,  8'h03);
        // The dropped header must not have opened a frame.
        idle(9);
        send_byte(8'h01);
        idle(9);
        send_byte(8'hFE);
        check("bp_no_frame_tx", tx_valid, 1'b0);
        check("bp_no_frame_err", err_cnt, 8'h03);

        // ---------------- err_cnt saturation ----------------
        tx_ready = 1'b0;
        send_frame(8'hAA, 8'h01, 8'hFE);
        rx_data  = 8'h33;
        rx_valid = 1'b1;
        idle(252);
        check("sat_reach", err_cnt, 8'hFF);
        idle(8);
        rx_valid = 1'b0;
        check("sat_hold", err_cnt, 8'hFF);
        tx_ready = 1'b1;
        tick();
        check("sat_tx_done", tx_valid, 1'b0);

        // ---------------- reset mid-frame ----------------
        send_byte(8'hAA);
        idle(9);
        send_byte(8'h01);
        idle(9);
        check("mid_led_before", led_en, 1'b1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mid_led",      led_en,   1'b0);
        check("mid_tx_valid", tx_valid, 1'b0);
        check("mid_err",      err_cnt,  8'h00);
        send_byte(8'hFE);
        check("mid_fe_tx",  tx_valid, 1'b0);
        check("mid_fe_led", led_en,   1'b0);
        tick();
        send_frame(8'hAA, 8'h01, 8'hFE);
        check("post_tx_valid", tx_valid, 1'b1);
        check("post_tx_data",  tx_data,  8'h06);
        check("post_led",      led_en,   1'b1);
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
